wb_port_arbiter: RTL

- Shares the two register-file write ports between the two in-order writeback pipes (p0 older, p1 younger) and a late, long-latency writeback source (cache-miss loads, multiply/divide results).
- Late results go into a small FIFO and drain into whichever port the pipes leave idle.
- Entries made stale by a younger pipe write to the same register are cancelled.
- A stall request forces a bubble when the late source is starved.

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_late_fifo.sv | 75 +++++++
 rtl/wb_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, constants and the starvation FSM encoding for the
// writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STALL
  } starve_state_e;

  function automatic logic addr_hit(input logic en, input logic [AW-1:0] a,
                                    input logic [AW-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/wb_late_fifo.sv
// Late-write FIFO: each entry carries a valid bit that two CAM ports can
// clear, so stale writes are dropped at the head instead of written.
module wb_late_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       push_valid_i,
  input  logic [AW-1:0]              push_addr_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic                       pop_i,
  input  logic                       clr0_en_i,
  input  logic [AW-1:0]              clr0_addr_i,
  input  logic                       clr1_en_i,
  input  logic [AW-1:0]              clr1_addr_i,
  output logic [AW-1:0]              head_addr_o,
  output logic [DW-1:0]              head_data_o,
  output logic                       head_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_hit(clr0_en_i, clr0_addr_i, addr_q[i]) ||
          addr_hit(clr1_en_i, clr1_addr_i, addr_q[i]))
        valid_d[i] = 1'b0;
    end
    if (push_i) valid_d[wptr_q] = push_valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; the valid bits and count
  // already guarantee nothing stale is ever read out.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wptr_q] <= push_addr_i;
      data_q[wptr_q] <= push_data_i;
    end
  end

  assign head_addr_o  = addr_q[rptr_q];
  assign head_data_o  = data_q[rptr_q];
  assign head_valid_o = (count_q != '0) && valid_q[rptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the two register-file write ports between the in-order pipes and a
// queued late-result source, cancelling stale late writes and forcing bubbles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_w_ena,
  input  logic [AW-1:0] p0_w_addr,
  input  logic [DW-1:0] p0_w_data,
  input  logic          p1_w_ena,
  input  logic [AW-1:0] p1_w_addr,
  input  logic [DW-1:0] p1_w_data,
  input  logic          lr_valid,
  output logic          lr_ready,
  input  logic [AW-1:0] lr_addr,
  input  logic [DW-1:0] lr_data,
  output logic          rf_we0,
  output logic [AW-1:0] rf_waddr0,
  output logic [DW-1:0] rf_wdata0,
  output logic          rf_we1,
  output logic [AW-1:0] rf_waddr1,
  output logic [DW-1:0] rf_wdata1,
  output logic          wb_stall
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic            e0, e1, we0_pipe;
  logic            free0, free1, any_free;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;
  logic            head_valid, head_live, fifo_empty;
  logic [CNTW-1:0] count;
  logic            drain, pop, bypass, push, push_valid;
  logic            late_go, late_p0, late_p1, blocked;
  logic [AW-1:0]   late_addr;
  logic [DW-1:0]   late_data;

  starve_state_e   state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d, cnt_inc;

  // p1 is the younger instruction, so on a same-address collision it wins.
  assign e0       = p0_w_ena && (p0_w_addr != ZERO_REG);
  assign e1       = p1_w_ena && (p1_w_addr != ZERO_REG);
  assign we0_pipe = e0 && !(e1 && (p0_w_addr == p1_w_addr));
  assign free1    = !e1;
  assign free0    = !we0_pipe;
  assign any_free = free1 || free0;

  function automatic logic pipe_hit(input logic [AW-1:0] a);
    return addr_hit(we0_pipe, p0_w_addr, a) || addr_hit(e1, p1_w_addr, a);
  endfunction

  wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_valid_i (push_valid),
    .push_addr_i  (lr_addr),
    .push_data_i  (lr_data),
    .pop_i        (pop),
    .clr0_en_i    (we0_pipe),
    .clr0_addr_i  (p0_w_addr),
    .clr1_en_i    (e1),
    .clr1_addr_i  (p1_w_addr),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  assign fifo_empty = (count == '0);
  assign head_live  = head_valid && !pipe_hit(head_addr);
  assign drain      = head_live && any_free;
  // An already-invalid head leaves without consuming a port.
  assign pop        = (!fifo_empty && !head_valid) || drain;

  assign lr_ready   = (count < CNTW'(DEPTH));
  assign bypass     = fifo_empty && any_free && lr_valid &&
                      (lr_addr != ZERO_REG) && !pipe_hit(lr_addr);
  assign push       = lr_valid && lr_ready && !bypass;
  assign push_valid = (lr_addr != ZERO_REG) && !pipe_hit(lr_addr);

  assign late_go   = drain || bypass;
  assign late_addr = drain ? head_addr : lr_addr;
  assign late_data = drain ? head_data : lr_data;
  assign late_p1   = late_go && free1;
  assign late_p0   = late_go && !free1;

  assign rf_we1    = !rst && (e1 || late_p1);
  assign rf_waddr1 = e1 ? p1_w_addr : late_addr;
  assign rf_wdata1 = e1 ? p1_w_data : late_data;
  assign rf_we0    = !rst && (we0_pipe || late_p0);
  assign rf_waddr0 = we0_pipe ? p0_w_addr : late_addr;
  assign rf_wdata0 = we0_pipe ? p0_w_data : late_data;

  assign blocked = head_live && !any_free;
  assign cnt_inc = cnt_q + 1'b1;

  // The counter reaching the limit on a blocked cycle arms the stall for the
  // following cycle, so upstream sees wb_stall after exactly LIMIT blocked cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (blocked) begin
          cnt_d   = SW'(1);
          state_d = (SW'(1) == LIMIT) ? ST_STALL : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pop || fifo_empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (blocked) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LIMIT) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (pop || fifo_empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_stall = (state_q == ST_STALL);

endmodule
